// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Multiplexed seven-segment driver. A binary value accepted over a
//   valid/ready handshake is converted to BCD by a sequential shift-add-3
//   engine, committed to a display buffer, and scanned across DIGITS
//   common-anode digits with leading-zero blanking, decimal points and an
//   overflow dash pattern.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : in_data is presented for loading
//   in_data      : unsigned binary value [WIDTH-1:0]
//   in_ready     : converter idle; load accepted on in_valid && in_ready
//   blank_lz     : 1 = dark leading zeros (live)
//   dp_mask      : per-digit decimal point enable (live)
//   seg_sel      : active-low digit select, bit 0 = least significant digit
//   seg_data     : active-low segments {dp,g,f,e,d,c,b,a}
module seg_scan_display #(
    parameter int WIDTH    = 16,
    parameter int DIGITS   = 6,
    parameter int SCAN_DIV = 83886
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    input  logic              blank_lz,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [DIGITS-1:0] seg_sel,
    output logic [7:0]        seg_data
);

    // Nibbles needed for the full input range: ceil(WIDTH*0.302)+1.
    localparam int NB = (WIDTH * 302 + 999) / 1000 + 1;
    // Scratch is at least DIGITS nibbles wide so the commit copy never
    // reaches past it; the extra nibbles simply stay zero.
    localparam int SN = (NB > DIGITS) ? NB : DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(SCAN_DIV);
    localparam int TW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t              state;
    logic [TW-1:0]       iter;
    logic [WIDTH-1:0]    sh;
    logic [SN*4-1:0]     bcd;
    logic [DIGITS*4-1:0] disp_buf;
    logic                ovf;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;

    logic                accept;
    logic [SN*4-1:0]     bcd_adj;
    logic [DIGITS*4-1:0] buf_next;
    logic                ovf_next;
    logic [IW-1:0]       msd;
    logic [3:0]          nib;
    logic                dp_bit;
    logic [6:0]          code;
    logic [DIGITS-1:0]   sel_next;
    logic [7:0]          data_next;

    assign accept = in_valid && in_ready;

    // One shift-add-3 step: adjust nibbles >= 5, then shift {bcd,sh} left.
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < SN; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_comb begin
        buf_next = bcd[DIGITS*4-1:0];
        ovf_next = 1'b0;
        for (int unsigned i = DIGITS; i < SN; i++) begin
            if (bcd[i*4 +: 4] != 4'd0)
                ovf_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            iter     <= '0;
            sh       <= '0;
            bcd      <= '0;
            disp_buf <= '0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sh       <= in_data;
                        bcd      <= '0;
                        iter     <= '0;
                        in_ready <= 1'b0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[SN*4-2:0], sh[WIDTH-1]};
                    sh  <= {sh[WIDTH-2:0], 1'b0};
                    if (iter == TW'(WIDTH - 1))
                        state <= COMMIT;
                    else
                        iter <= iter + TW'(1);
                end
                COMMIT: begin
                    disp_buf <= buf_next;
                    ovf      <= ovf_next;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: begin
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Scan timing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CW'(SCAN_DIV - 1)) begin
            cnt <= '0;
            if (idx == IW'(DIGITS - 1))
                idx <= '0;
            else
                idx <= idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Most significant nonzero buffer nibble (0 when the buffer is zero).
    always_comb begin
        msd = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (disp_buf[i*4 +: 4] != 4'd0)
                msd = IW'(i);
        end
    end

    always_comb begin
        nib      = 4'd0;
        dp_bit   = 1'b0;
        sel_next = '1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx) begin
                nib         = disp_buf[i*4 +: 4];
                dp_bit      = dp_mask[i];
                sel_next[i] = 1'b0;
            end
        end
    end

    always_comb begin
        case (nib)
            4'd0:    code = 7'h40;
            4'd1:    code = 7'h79;
            4'd2:    code = 7'h24;
            4'd3:    code = 7'h30;
            4'd4:    code = 7'h19;
            4'd5:    code = 7'h12;
            4'd6:    code = 7'h02;
            4'd7:    code = 7'h78;
            4'd8:    code = 7'h00;
            4'd9:    code = 7'h10;
            default: code = 7'h7F;
        endcase
        if (ovf)
            data_next = {~dp_bit, 7'h3F};
        else if (blank_lz && (idx != '0) && (idx > msd))
            data_next = {~dp_bit, 7'h7F};
        else
            data_next = {~dp_bit, code};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sel  <= '1;
            seg_data <= 8'hFF;
        end else begin
            seg_sel  <= sel_next;
            seg_data <= data_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
//   Directed bench for seg_scan_display. Two instances share clock, reset,
//   blank_lz and dp_mask: u16 (WIDTH=16) and u24 (WIDTH=24), both DIGITS=6,
//   SCAN_DIV=4.
module tb_seg_scan_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        blank_lz;
    logic [5:0]  dp_mask;

    logic        iv16, rdy16;
    logic [15:0] id16;
    logic [5:0]  sel16;
    logic [7:0]  dat16;

    logic        iv24, rdy24;
    logic [23:0] id24;
    logic [5:0]  sel24;
    logic [7:0]  dat24;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    seg_scan_display #(.WIDTH(16), .DIGITS(6), .SCAN_DIV(4)) u16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (iv16),
        .in_data  (id16),
        .in_ready (rdy16),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .seg_sel  (sel16),
        .seg_data (dat16)
    );

    seg_scan_display #(.WIDTH(24), .DIGITS(6), .SCAN_DIV(4)) u24 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (iv24),
        .in_data  (id24),
        .in_ready (rdy24),
        .blank_lz (blank_lz),
        .dp_mask  (dp_mask),
        .seg_sel  (sel24),
        .seg_data (dat24)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Load a value; returns the number of negedges in_ready was seen low.
    // With hold=1, in_valid stays high (junk data) throughout the conversion.
    task automatic load(input bit w24, input int unsigned value, input bit hold,
                        output int unsigned lowcnt);
        int unsigned guard;
        guard = 0;
        @(negedge clk);
        while (!(w24 ? rdy24 : rdy16) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (w24) begin iv24 = 1'b1; id24 = value[23:0]; end
        else     begin iv16 = 1'b1; id16 = value[15:0]; end
        @(negedge clk);
        lowcnt = 0;
        while (!(w24 ? rdy24 : rdy16) && lowcnt < 100) begin
            if (w24) begin iv24 = hold; id24 = 24'd999; end
            else     begin iv16 = hold; id16 = 16'd999; end
            @(negedge clk);
            lowcnt++;
        end
        iv16 = 1'b0;
        iv24 = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_digit(input bit w24, input int unsigned d, output logic [7:0] v);
        logic [5:0] want;
        int unsigned guard;
        want  = ~(6'd1 << d);
        guard = 0;
        while ((w24 ? sel24 : sel16) != want && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if ((w24 ? sel24 : sel16) != want) begin
            check("sel_timeout", 32'(w24 ? sel24 : sel16), 32'(want));
            v = 8'h00;
        end else begin
            v = w24 ? dat24 : dat16;
        end
    endtask

    task automatic check_digits(input bit w24, input string tag, input logic [47:0] exp);
        logic [7:0] v;
        logic [7:0] e;
        for (int d = 0; d < 6; d++) begin
            e = exp[d*8 +: 8];
            read_digit(w24, d, v);
            check($sformatf("%s_d%0d", tag, d), 32'(v), 32'(e));
        end
    endtask

    initial begin
        int unsigned lc;
        logic [7:0] v;
        logic [5:0] es;
        rst_n    = 1'b0;
        blank_lz = 1'b1;
        dp_mask  = 6'b0;
        iv16 = 1'b0; id16 = '0;
        iv24 = 1'b0; id24 = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(sel16), 32'h3F);
        check("rst_data", 32'(dat16), 32'hFF);
        check("rst_ready", 32'(rdy16), 32'h1);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        // Mid-scan asynchronous reset
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(sel16), 32'h3F);
        check("arst_data", 32'(dat16), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        // Scan order and per-digit hold after release, including the wrap
        for (int k = 0; k < 28; k++) begin
            @(negedge clk);
            es = ~(6'd1 << ((k / 4) % 6));
            check("scan_sel", 32'(sel16), 32'(es));
            check("scan_data", 32'(dat16), (k % 24) < 4 ? 32'hC0 : 32'hFF);
        end

        // Load 12345 with in_valid held through conversion
        blank_lz = 1'b0;
        load(1'b0, 12345, 1'b1, lc);
        check("busy_16", lc, 17);
        check("ready_after", 32'(rdy16), 32'h1);
        check_digits(1'b0, "v12345", {8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92});
        check("ready_still", 32'(rdy16), 32'h1);

        // Overflow on the 24-bit instance
        load(1'b1, 999999, 1'b0, lc);
        check("busy_24", lc, 25);
        check_digits(1'b1, "v999999", {8'h90, 8'h90, 8'h90, 8'h90, 8'h90, 8'h90});
        load(1'b1, 1000000, 1'b0, lc);
        check_digits(1'b1, "ovf", {8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF});
        load(1'b1, 42, 1'b0, lc);
        read_digit(1'b1, 0, v);
        check("v42_d0", 32'(v), 32'hA4);
        read_digit(1'b1, 1, v);
        check("v42_d1", 32'(v), 32'h99);

        // Blanking and decimal point
        blank_lz = 1'b1;
        dp_mask  = 6'b000100;
        load(1'b0, 7, 1'b0, lc);
        check_digits(1'b0, "blank7", {8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hFF, 8'hF8});
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        read_digit(1'b0, 1, v);
        check("noblank_d1", 32'(v), 32'hC0);
        read_digit(1'b0, 2, v);
        check("noblank_d2", 32'(v), 32'h40);

        // Reset during a conversion
        dp_mask  = 6'b0;
        blank_lz = 1'b1;
        @(negedge clk);
        iv16 = 1'b1;
        id16 = 16'd255;
        @(negedge clk);
        iv16 = 1'b0;
        check("conv_busy", 32'(rdy16), 32'h0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(rdy16), 32'h1);
        check("midrst_sel", 32'(sel16), 32'h3F);
        check("midrst_data", 32'(dat16), 32'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("midrst_ready2", 32'(rdy16), 32'h1);
        check_digits(1'b0, "midrst", {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
